// File: rtl/rsff_checker_pkg.sv
// Shared definitions for the RS flip-flop checker: FSM states, the {S,R}
// command decode and the registered event bundle.
package rsff_checker_pkg;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOST  = 2'd2
    } state_t;

    // Command encoding is {S, R}.
    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_RST  = 2'b01,
        CMD_SET  = 2'b10,
        CMD_ILL  = 2'b11
    } cmd_t;

    typedef struct packed {
        logic err;
        logic cmp_err;
        logic illegal;
    } evt_t;

    function automatic cmd_t decode(input logic r, input logic s);
        return cmd_t'({s, r});
    endfunction

endpackage

// File: rtl/rsff_model.sv
// Golden RS flip-flop. exp_q is forced to 0 on an illegal command because the
// model is unknown until the next set/reset.
module rsff_model
    import rsff_checker_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic R,
    input  logic S,
    input  logic load,
    input  logic load_val,
    output logic exp_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= 1'b0;
        end else if (load) begin
            exp_q <= load_val;
        end else begin
            case (decode(R, S))
                CMD_SET: exp_q <= 1'b1;
                CMD_RST: exp_q <= 1'b0;
                CMD_ILL: exp_q <= 1'b0;
                default: exp_q <= exp_q;
            endcase
        end
    end

endmodule

// File: rtl/rsff_checker.sv
// Output-side monitor for the lab RSFF: tracks a golden model and flags
// Q mismatches, complement faults and illegal R=S=1 commands.
module rsff_checker
    import rsff_checker_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             R,
    input  logic             S,
    input  logic             Q,
    input  logic             nQ,
    output logic             exp_q,
    output logic             valid,
    output logic             err,
    output logic             cmp_err,
    output logic             illegal,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] ill_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state, state_nxt;
    cmd_t   cmd;
    logic   load;
    evt_t   evt_nxt, evt_q;

    rsff_model u_model (
        .clk      (clk),
        .rst_n    (rst_n),
        .R        (R),
        .S        (S),
        .load     (load),
        .load_val (Q),
        .exp_q    (exp_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_SYNC;
        else        state <= state_nxt;
    end

    // Compare uses exp_q as held before the edge; model update happens at it.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        cmd       = decode(R, S);
        evt_nxt   = '0;

        case (state)
            ST_TRACK: begin
                if (cmd == CMD_ILL) state_nxt = ST_LOST;
            end
            default: begin
                case (cmd)
                    CMD_ILL:          state_nxt = ST_LOST;
                    CMD_SET, CMD_RST: state_nxt = ST_TRACK;
                    default: begin
                        // Only a fresh SYNC may adopt the flop's own Q.
                        if (state == ST_SYNC && Q != nQ) begin
                            load      = 1'b1;
                            state_nxt = ST_TRACK;
                        end
                    end
                endcase
            end
        endcase

        evt_nxt.err     = en && (state == ST_TRACK) && (Q != exp_q);
        evt_nxt.cmp_err = en && (Q == nQ);
        evt_nxt.illegal = en && (cmd == CMD_ILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q   <= '0;
            valid   <= 1'b0;
            err_cnt <= '0;
            ill_cnt <= '0;
        end else begin
            evt_q <= evt_nxt;
            valid <= (state == ST_TRACK);
            if (evt_nxt.err && err_cnt != CNT_MAX)     err_cnt <= err_cnt + CNT_ONE;
            if (evt_nxt.illegal && ill_cnt != CNT_MAX) ill_cnt <= ill_cnt + CNT_ONE;
        end
    end

    assign err     = evt_q.err;
    assign cmp_err = evt_q.cmp_err;
    assign illegal = evt_q.illegal;

endmodule

// File: tb/tb_rsff_checker.sv
// Directed plus random bench for rsff_checker against a behavioural RSFF model.
module tb_rsff_checker;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, en, R, S, Q, nQ;
    logic          exp_q, valid, err, cmp_err, illegal;
    logic [CW-1:0] err_cnt, ill_cnt;

    int total = 0;
    int bad   = 0;

    // reference model
    bit m_known, m_lost, m_exp, m_valid, m_errp, m_cmpp, m_illp;
    int m_err_cnt, m_ill_cnt;

    rsff_checker #(.CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .R       (R),
        .S       (S),
        .Q       (Q),
        .nQ      (nQ),
        .exp_q   (exp_q),
        .valid   (valid),
        .err     (err),
        .cmp_err (cmp_err),
        .illegal (illegal),
        .err_cnt (err_cnt),
        .ill_cnt (ill_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_known = 0; m_lost = 0; m_exp = 0; m_valid = 0;
        m_errp = 0; m_cmpp = 0; m_illp = 0;
        m_err_cnt = 0; m_ill_cnt = 0;
    endtask

    task automatic model_edge(input bit r, input bit s, input bit q, input bit nq, input bit e);
        m_errp = e && m_known && (q != m_exp);
        m_cmpp = e && (q == nq);
        m_illp = e && r && s;
        if (m_errp && m_err_cnt < CMAX) m_err_cnt++;
        if (m_illp && m_ill_cnt < CMAX) m_ill_cnt++;
        m_valid = m_known;
        if (r && s) begin
            m_known = 0; m_lost = 1; m_exp = 0;
        end else if (r || s) begin
            m_known = 1; m_lost = 0; m_exp = s;
        end else if (!m_known && !m_lost && q != nq) begin
            m_known = 1; m_exp = q;
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ":exp_q"},   exp_q,   m_known ? m_exp : 1'b0);
        chk({where, ":valid"},   valid,   m_valid);
        chk({where, ":err"},     err,     m_errp);
        chk({where, ":cmp_err"}, cmp_err, m_cmpp);
        chk({where, ":illegal"}, illegal, m_illp);
        chk({where, ":err_cnt"}, err_cnt, m_err_cnt);
        chk({where, ":ill_cnt"}, ill_cnt, m_ill_cnt);
    endtask

    task automatic step(input string where, input bit r, input bit s,
                        input bit q, input bit nq, input bit e);
        R = r; S = s; Q = q; nQ = nq; en = e;
        @(posedge clk);
        #1;
        model_edge(r, s, q, nq, e);
        check_all(where);
    endtask

    initial begin
        rst_n = 0; en = 1; R = 0; S = 0; Q = 0; nQ = 1;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1;

        // set, then first compare
        step("set",      0, 1, 0, 1, 1);
        step("set_chk",  0, 0, 1, 0, 1);
        // reset command, then forced wrong Q
        step("rst_cmd",  1, 0, 1, 0, 1);
        step("mis",      0, 0, 1, 0, 1);
        step("mis_end",  0, 0, 0, 1, 1);
        // illegal, arbitrary Q in LOST, then recover
        step("ill",      1, 1, 0, 1, 1);
        step("lost_a",   0, 0, 1, 0, 1);
        step("lost_b",   0, 0, 0, 1, 1);
        step("recover",  1, 0, 1, 0, 1);
        step("rec_chk",  0, 0, 0, 1, 1);
        // complement fault, enabled then disabled
        for (int i = 0; i < 3; i++) step("cmp_en",  0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) step("cmp_dis", 0, 0, 1, 1, 0);
        step("cmp_off",  0, 0, 0, 1, 1);

        // saturation from a clean start
        #2; rst_n = 0; #1;
        model_reset();
        check_all("rst2");
        @(negedge clk);
        rst_n = 1;
        step("sat_sync", 1, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step("sat", 0, 0, 1, 0, 1);

        // asynchronous reset mid-stream with saturated counter
        #2; rst_n = 0; #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1;
        step("sync_a",   0, 0, 1, 1, 1);
        step("sync_b",   0, 0, 0, 0, 1);
        step("adopt",    0, 0, 1, 0, 1);
        step("adopt_ck", 0, 0, 1, 0, 1);

        for (int i = 0; i < 400; i++) begin
            int  pick;
            bit  r, s, q, nq, e;
            pick = int'($urandom_range(0, 9));
            r = (pick == 0) || (pick >= 4 && pick <= 6);
            s = (pick >= 0 && pick <= 3);
            q  = ($urandom_range(0, 3) != 0) ? (m_known ? m_exp : 1'(($urandom))) : 1'($urandom);
            nq = ($urandom_range(0, 5) != 0) ? ~q : 1'($urandom);
            e  = ($urandom_range(0, 9) != 0);
            step("rand", r, s, q, nq, e);
            if (i == 200) begin
                #2; rst_n = 0; #1;
                model_reset();
                check_all("rand_rst");
                @(negedge clk);
                rst_n = 1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
